// File: rtl/ad_pkg.sv
// rtl/ad_pkg.sv - shared constants and width helpers for the digit scanner
package ad_pkg;

  // Ceiling log2 for elaboration-time widths
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Select counter width, never narrower than one bit
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Anode drive with every digit dark (active-low), sliced to DIGITS by users
  localparam logic [15:0] ANODE_OFF = 16'hFFFF;

endpackage

// File: rtl/ad_mux_param.sv
// rtl/ad_mux_param.sv - combinational N:1 selector over a flattened bus
module ad_mux_param
  import ad_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = 4,
  localparam int SW = sel_width(N)
) (
  input  logic [N*DW-1:0] bus,
  input  logic [SW-1:0]   sel,
  output logic [DW-1:0]   y
);

  // Pick lane sel; out-of-range indices (non-power-of-two N) read as zero
  always_comb begin
    y = '0;
    if (int'(sel) < N) y = bus[sel*DW +: DW];
  end

endmodule

// File: rtl/ad_scan_mux.sv
// rtl/ad_scan_mux.sv - time-multiplexed seven-segment digit scanner with shadow buffer
module ad_scan_mux
  import ad_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int DW        = 4,
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  localparam int SELW     = sel_width(DIGITS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIGITS*DW-1:0] d_flat,
  input  logic [DIGITS-1:0]    digit_en,
  input  logic [DIGITS-1:0]    dp_in,
  input  logic                 update,
  output logic [DW-1:0]        Y,
  output logic [SELW-1:0]      select,
  output logic [DIGITS-1:0]    anode,
  output logic                 dp_n,
  output logic                 frame_start
);

  localparam int TW = clog2(TICK_DIV);

  logic [TW-1:0]          tick, tick_nx;
  logic [SELW-1:0]        sel_nx;
  logic                   pending, pending_nx;
  logic [DIGITS*DW-1:0]   sh_d, sh_d_nx;
  logic [DIGITS-1:0]      sh_en, sh_en_nx, sh_dp, sh_dp_nx;
  logic                   slot_wrap, frame_wrap, load;
  logic                   blank_nx;
  logic [DW-1:0]          y_nx;
  logic                   en_sel, dp_sel;
  logic [DIGITS-1:0]      anode_nx;
  logic                   dp_n_nx;

  // Next counter state and shadow contents; the shadow only reloads on the frame wrap
  always_comb begin
    slot_wrap  = (tick == TW'(TICK_DIV - 1));
    frame_wrap = slot_wrap && (select == SELW'(DIGITS - 1));
    load       = frame_wrap && (pending || update);
    tick_nx    = slot_wrap ? '0 : tick + 1'b1;
    sel_nx     = select;
    if (slot_wrap) sel_nx = frame_wrap ? '0 : select + 1'b1;
    pending_nx = frame_wrap ? 1'b0 : (pending | update);
    sh_d_nx    = load ? d_flat   : sh_d;
    sh_en_nx   = load ? digit_en : sh_en;
    sh_dp_nx   = load ? dp_in    : sh_dp;
  end

  // Blank gap covers the first BLANK_CYC ticks of every slot
  generate
    if (BLANK_CYC == 0) begin : g_no_gap
      assign blank_nx = 1'b0;
    end else begin : g_gap
      assign blank_nx = (tick_nx < TW'(BLANK_CYC));
    end
  endgenerate

  // Outputs are looked up from the next-state select so they land with it
  ad_mux_param #(.N(DIGITS), .DW(DW)) u_mux_d  (.bus(sh_d_nx),  .sel(sel_nx), .y(y_nx));
  ad_mux_param #(.N(DIGITS), .DW(1))  u_mux_en (.bus(sh_en_nx), .sel(sel_nx), .y(en_sel));
  ad_mux_param #(.N(DIGITS), .DW(1))  u_mux_dp (.bus(sh_dp_nx), .sel(sel_nx), .y(dp_sel));

  // Anode and decimal point drive for the upcoming cycle
  always_comb begin
    anode_nx = ANODE_OFF[DIGITS-1:0];
    if (!blank_nx && en_sel) anode_nx[sel_nx] = 1'b0;
    dp_n_nx = blank_nx | ~(dp_sel & en_sel);
  end

  // State and registered outputs; reset drops any pending load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick        <= '0;
      select      <= '0;
      pending     <= 1'b0;
      sh_d        <= '0;
      sh_en       <= '0;
      sh_dp       <= '0;
      Y           <= '0;
      anode       <= ANODE_OFF[DIGITS-1:0];
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      tick        <= tick_nx;
      select      <= sel_nx;
      pending     <= pending_nx;
      sh_d        <= sh_d_nx;
      sh_en       <= sh_en_nx;
      sh_dp       <= sh_dp_nx;
      Y           <= y_nx;
      anode       <= anode_nx;
      dp_n        <= dp_n_nx;
      frame_start <= frame_wrap;
    end
  end

endmodule
